wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL take parameter XLEN, default core_pkg::XLEN, as the result data width.
REQ-002 The block SHALL take parameter NUM_FU, default 4, as the number of functional-unit result sources; only 4 is required.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 2, as the per-source result buffer depth.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all buffered results and output valids.
REQ-007 fu_valid[NUM_FU]  input  1 each  source i offers a result this cycle.
REQ-008 fu_tag[NUM_FU]  input  core_pkg::preg_tag_t each  destination physical register of the result.
REQ-009 fu_data[NUM_FU]  input  XLEN each  result value.
REQ-010 fu_ready[NUM_FU]  output  1 each  source i's buffer can accept a result.
REQ-011 wen0 / wtag0 / wdata0  output  1 / preg_tag_t / XLEN  PRF write port 0, registered.
REQ-012 wen1 / wtag1 / wdata1  output  1 / preg_tag_t / XLEN  PRF write port 1, registered.
REQ-013 pending  output  1  any source buffer is non-empty or any wen is asserted.

Function
REQ-014 Each source SHALL own a FIFO_DEPTH-entry FIFO of {tag, data} with a count register in the range 0..FIFO_DEPTH.
REQ-015 fu_ready[i] SHALL equal (count[i] < FIFO_DEPTH), decoded from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-016 A push SHALL occur on a rising edge where fu_valid[i] && fu_ready[i]; fu_valid without ready SHALL be ignored with no state change.
REQ-017 A 2-bit round-robin pointer rr SHALL be kept; the first grant SHALL go to the first non-empty FIFO searching rr, rr+1, ... mod NUM_FU.
REQ-018 The second grant SHALL go to the next non-empty FIFO after the first grant in the same circular order, excluding the first grant's FIFO; at most one pop per FIFO per cycle.
REQ-019 The first-granted head SHALL be registered onto port 0 and the second onto port 1; an ungranted port SHALL have wen=0 next cycle.
REQ-020 wtag/wdata SHALL hold their previous values when the corresponding wen is 0.
REQ-021 rr SHALL update to (index of last grant this cycle + 1) mod NUM_FU; with no grant rr SHALL be unchanged.
REQ-022 Latency SHALL be exactly 2 edges minimum: a push at edge E SHALL make wen visible after edge E+1 at the earliest.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve FIFO order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 No tag comparison between ports SHALL be performed; equal tags on both ports SHALL pass through unchanged.
REQ-025 flush=1 at an edge SHALL zero all counts and FIFO pointers, deassert wen0/wen1, reset rr to 0, and discard any push or grant of that cycle.
REQ-026 During a flush cycle fu_ready SHALL reflect pre-flush counts, but accepted pushes SHALL still be discarded.

Reset
REQ-027 reset_n=0 SHALL immediately and asynchronously clear all counts, FIFO pointers, and rr, and drive wen0=wen1=0, wtag0=wtag1=0, wdata0=wdata1=0.
REQ-028 After reset fu_ready SHALL be all 1 and pending SHALL be 0; FIFO storage contents need not be reset.
REQ-029 Assertion of reset_n mid-operation SHALL drop all buffered results, with no partial write appearing on wen.

Verification
REQ-030 Single push: FU2 pushes tag 5, data 0xDEAD at edge E -> after E+1: wen0=1, wtag0=5, wdata0=0xDEAD, wen1=0; next cycle wen0=0.
REQ-031 Four simultaneous pushes from reset (rr=0), tags 10..13 -> cycle 1: ports carry tags 10 and 11, rr=2; cycle 2: tags 12 and 13; pending returns to 0 after the last wen.
REQ-032 Backpressure: FU0 pushes every cycle with outputs unconsumed by other FUs -> fu_ready[0] stays high; FU0-FU3 all pushing continuously -> each FU drains at 1/2 rate, fu_ready toggles, no loss or reorder per FU.
REQ-033 Full boundary: FU1 count=2 with a pop in progress -> fu_ready[1]=0 that cycle; a push offered is not accepted; count=1 next cycle with ready=1.
REQ-034 Flush: 3 FIFOs non-empty and wen0=1 -> after flush edge: all counts 0, wen0=wen1=0, rr=0, push offered on the flush cycle is absent afterward.
REQ-035 Async reset mid-stream: reset_n falls between edges -> wen0/wen1 drop to 0 before the next edge; after release no stale tag is written.

Source files
------------

// File: rtl/wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | wb_arbiter : buffers results from NUM_FU sources and merges them onto     |
// |              two registered PRF write ports with round-robin priority.    |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package core_pkg;
   localparam int XLEN   = 32;
   localparam int PREG_W = 6;
   typedef logic [PREG_W-1:0] preg_tag_t;
endpackage

module wb_arbiter #(
   parameter int XLEN       = core_pkg::XLEN,
   parameter int NUM_FU     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic [NUM_FU-1:0]   fu_valid,
   input  core_pkg::preg_tag_t fu_tag  [NUM_FU],
   input  logic [XLEN-1:0]     fu_data [NUM_FU],
   output logic [NUM_FU-1:0]   fu_ready,
   output logic                wen0,
   output core_pkg::preg_tag_t wtag0,
   output logic [XLEN-1:0]     wdata0,
   output logic                wen1,
   output core_pkg::preg_tag_t wtag1,
   output logic [XLEN-1:0]     wdata1,
   output logic                pending
);

   localparam int c_RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   logic [c_CNT_W-1:0]  count_q  [NUM_FU];
   logic [c_CNT_W-1:0]  count_d  [NUM_FU];
   logic [c_PTR_W-1:0]  rd_ptr_q [NUM_FU];
   logic [c_PTR_W-1:0]  rd_ptr_d [NUM_FU];
   logic [c_PTR_W-1:0]  wr_ptr_q [NUM_FU];
   logic [c_PTR_W-1:0]  wr_ptr_d [NUM_FU];
   core_pkg::preg_tag_t tag_mem_q  [NUM_FU][FIFO_DEPTH];
   core_pkg::preg_tag_t tag_mem_d  [NUM_FU][FIFO_DEPTH];
   logic [XLEN-1:0]     data_mem_q [NUM_FU][FIFO_DEPTH];
   logic [XLEN-1:0]     data_mem_d [NUM_FU][FIFO_DEPTH];
   logic [c_RR_W-1:0]   rr_q, rr_d;
   logic                wen0_q, wen0_d, wen1_q, wen1_d;
   core_pkg::preg_tag_t wtag0_q, wtag0_d, wtag1_q, wtag1_d;
   logic [XLEN-1:0]     wdata0_q, wdata0_d, wdata1_q, wdata1_d;

   logic [NUM_FU-1:0]   w_not_empty;
   logic [NUM_FU-1:0]   w_push;
   logic [NUM_FU-1:0]   w_pop;
   logic                w_g0_v, w_g1_v;
   logic [c_RR_W-1:0]   w_g0_idx, w_g1_idx;

   function automatic logic [c_RR_W-1:0] wrap_add(input logic [c_RR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_FU) s = s - NUM_FU;
      return c_RR_W'(s);
   endfunction

   function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
   endfunction

   // Ready and occupancy come from registered counts only, so a pop in flight never raises ready.
   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_status
      assign fu_ready[gi]    = (count_q[gi] < c_CNT_FULL);
      assign w_not_empty[gi] = (count_q[gi] != '0);
   end

   assign pending = (|w_not_empty) | wen0_q | wen1_q;
   assign wen0    = wen0_q;
   assign wtag0   = wtag0_q;
   assign wdata0  = wdata0_q;
   assign wen1    = wen1_q;
   assign wtag1   = wtag1_q;
   assign wdata1  = wdata1_q;

   always_comb begin
      w_g0_v   = 1'b0;
      w_g0_idx = '0;
      w_g1_v   = 1'b0;
      w_g1_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (!w_g0_v && w_not_empty[wrap_add(rr_q, k)]) begin
            w_g0_v   = 1'b1;
            w_g0_idx = wrap_add(rr_q, k);
         end
      end
      // Second grant continues the circular search just past the first winner.
      for (int k = 1; k < NUM_FU; k++) begin
         if (w_g0_v && !w_g1_v && w_not_empty[wrap_add(w_g0_idx, k)]) begin
            w_g1_v   = 1'b1;
            w_g1_idx = wrap_add(w_g0_idx, k);
         end
      end
   end

   always_comb begin
      w_push = '0;
      w_pop  = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         w_push[i] = fu_valid[i] & fu_ready[i] & ~flush;
         w_pop[i]  = ((w_g0_v && (w_g0_idx == c_RR_W'(i))) ||
                      (w_g1_v && (w_g1_idx == c_RR_W'(i)))) & ~flush;
      end
   end

   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      tag_mem_d  = tag_mem_q;
      data_mem_d = data_mem_q;
      rr_d       = rr_q;
      wen0_d     = 1'b0;
      wtag0_d    = wtag0_q;
      wdata0_d   = wdata0_q;
      wen1_d     = 1'b0;
      wtag1_d    = wtag1_q;
      wdata1_d   = wdata1_q;
      if (flush) begin
         for (int i = 0; i < NUM_FU; i++) begin
            count_d[i]  = '0;
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
         end
         rr_d = '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i]) begin
               tag_mem_d[i][wr_ptr_q[i]]  = fu_tag[i];
               data_mem_d[i][wr_ptr_q[i]] = fu_data[i];
               wr_ptr_d[i]                = next_ptr(wr_ptr_q[i]);
            end
            if (w_pop[i]) rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
            if (w_push[i] && !w_pop[i]) count_d[i] = count_q[i] + c_CNT_ONE;
            else if (w_pop[i] && !w_push[i]) count_d[i] = count_q[i] - c_CNT_ONE;
            if (w_g0_v && (w_g0_idx == c_RR_W'(i))) begin
               wen0_d   = 1'b1;
               wtag0_d  = tag_mem_q[i][rd_ptr_q[i]];
               wdata0_d = data_mem_q[i][rd_ptr_q[i]];
            end
            if (w_g1_v && (w_g1_idx == c_RR_W'(i))) begin
               wen1_d   = 1'b1;
               wtag1_d  = tag_mem_q[i][rd_ptr_q[i]];
               wdata1_d = data_mem_q[i][rd_ptr_q[i]];
            end
         end
         if (w_g1_v)      rr_d = wrap_add(w_g1_idx, 1);
         else if (w_g0_v) rr_d = wrap_add(w_g0_idx, 1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_FU; i++) begin
            count_q[i]  <= '0;
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
         end
         rr_q     <= '0;
         wen0_q   <= 1'b0;
         wtag0_q  <= '0;
         wdata0_q <= '0;
         wen1_q   <= 1'b0;
         wtag1_q  <= '0;
         wdata1_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rr_q     <= rr_d;
         wen0_q   <= wen0_d;
         wtag0_q  <= wtag0_d;
         wdata0_q <= wdata0_d;
         wen1_q   <= wen1_d;
         wtag1_q  <= wtag1_d;
         wdata1_q <= wdata1_d;
      end
   end

   // Buffer storage carries no reset; validity is tracked by the counts.
   always_ff @(posedge clk) begin
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter : directed and random stimulus against a queue-based model. |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter;
   localparam int N  = 4;
   localparam int D  = 2;
   localparam int XL = 32;

   logic                clk      = 1'b0;
   logic                reset_n  = 1'b0;
   logic                flush    = 1'b0;
   logic [N-1:0]        fu_valid = '0;
   core_pkg::preg_tag_t fu_tag  [N];
   logic [XL-1:0]       fu_data [N];
   logic [N-1:0]        fu_ready;
   logic                wen0, wen1, pending;
   core_pkg::preg_tag_t wtag0, wtag1;
   logic [XL-1:0]       wdata0, wdata1;

   int checks   = 0;
   int failures = 0;

   core_pkg::preg_tag_t mq_tag  [N][$];
   logic [XL-1:0]       mq_data [N][$];
   int                  m_rr;
   logic                m_wen0, m_wen1;
   core_pkg::preg_tag_t m_wtag0, m_wtag1;
   logic [XL-1:0]       m_wdata0, m_wdata1;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XL), .NUM_FU(N), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .fu_valid (fu_valid),
      .fu_tag   (fu_tag),
      .fu_data  (fu_data),
      .fu_ready (fu_ready),
      .wen0     (wen0),
      .wtag0    (wtag0),
      .wdata0   (wdata0),
      .wen1     (wen1),
      .wtag1    (wtag1),
      .wdata1   (wdata1),
      .pending  (pending)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mq_tag[i].delete();
         mq_data[i].delete();
      end
      m_rr = 0;
      m_wen0 = 1'b0; m_wtag0 = '0; m_wdata0 = '0;
      m_wen1 = 1'b0; m_wtag1 = '0; m_wdata1 = '0;
   endtask

   // One clock edge of the arbiter behaviour, using the inputs currently driven.
   task automatic model_edge();
      int sz [N];
      int g0, g1, idx;
      for (int i = 0; i < N; i++) sz[i] = mq_tag[i].size();
      if (flush) begin
         for (int i = 0; i < N; i++) begin
            mq_tag[i].delete();
            mq_data[i].delete();
         end
         m_wen0 = 1'b0;
         m_wen1 = 1'b0;
         m_rr   = 0;
         return;
      end
      g0 = -1;
      g1 = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_rr + k) % N;
         if (g0 < 0 && sz[idx] > 0) g0 = idx;
      end
      if (g0 >= 0) begin
         for (int k = 1; k < N; k++) begin
            idx = (g0 + k) % N;
            if (g1 < 0 && sz[idx] > 0) g1 = idx;
         end
      end
      m_wen0 = (g0 >= 0);
      m_wen1 = (g1 >= 0);
      if (g0 >= 0) begin
         m_wtag0  = mq_tag[g0].pop_front();
         m_wdata0 = mq_data[g0].pop_front();
      end
      if (g1 >= 0) begin
         m_wtag1  = mq_tag[g1].pop_front();
         m_wdata1 = mq_data[g1].pop_front();
      end
      for (int i = 0; i < N; i++) begin
         if (fu_valid[i] && sz[i] < D) begin
            mq_tag[i].push_back(fu_tag[i]);
            mq_data[i].push_back(fu_data[i]);
         end
      end
      if (g1 >= 0)      m_rr = (g1 + 1) % N;
      else if (g0 >= 0) m_rr = (g0 + 1) % N;
   endtask

   function automatic logic model_pending();
      logic p;
      p = m_wen0 | m_wen1;
      for (int i = 0; i < N; i++) if (mq_tag[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic check_ready();
      for (int i = 0; i < N; i++)
         check($sformatf("fu_ready%0d", i), 64'(fu_ready[i]), 64'(mq_tag[i].size() < D));
   endtask

   task automatic check_outputs();
      check("wen0",    64'(wen0),    64'(m_wen0));
      check("wtag0",   64'(wtag0),   64'(m_wtag0));
      check("wdata0",  64'(wdata0),  64'(m_wdata0));
      check("wen1",    64'(wen1),    64'(m_wen1));
      check("wtag1",   64'(wtag1),   64'(m_wtag1));
      check("wdata1",  64'(wdata1),  64'(m_wdata1));
      check("pending", 64'(pending), 64'(model_pending()));
   endtask

   task automatic do_cycle();
      check_ready();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_idle();
      flush    = 1'b0;
      fu_valid = '0;
   endtask

   task automatic set_random(input int flush_odds);
      flush    = (flush_odds > 0) && ($urandom_range(0, flush_odds - 1) == 0);
      fu_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
         fu_tag[i]  = core_pkg::preg_tag_t'($urandom);
         fu_data[i] = $urandom;
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         fu_tag[i]  = '0;
         fu_data[i] = '0;
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_wen0",    64'(wen0),     64'(0));
      check("rst_wdata0",  64'(wdata0),   64'(0));
      check("rst_wtag1",   64'(wtag1),    64'(0));
      check("rst_ready",   64'(fu_ready), 64'hF);
      check("rst_pending", 64'(pending),  64'(0));
      reset_n = 1'b1;

      // Single push from FU2: two-edge latency onto port 0.
      set_idle();
      fu_valid[2] = 1'b1; fu_tag[2] = 6'd5; fu_data[2] = 32'hDEAD;
      do_cycle();
      check("single_lat_wen0", 64'(wen0), 64'(0));
      set_idle();
      do_cycle();
      check("single_wen0",  64'(wen0),   64'(1));
      check("single_wtag0", 64'(wtag0),  64'(5));
      check("single_data0", 64'(wdata0), 64'hDEAD);
      check("single_wen1",  64'(wen1),   64'(0));
      do_cycle();
      check("single_drop",  64'(wen0),   64'(0));

      // Flush returns rr to 0, then four simultaneous pushes.
      flush = 1'b1;
      do_cycle();
      set_idle();
      fu_valid = 4'hF;
      for (int i = 0; i < N; i++) begin
         fu_tag[i]  = core_pkg::preg_tag_t'(10 + i);
         fu_data[i] = 32'h100 + 32'(i);
      end
      do_cycle();
      set_idle();
      do_cycle();
      check("four_c1_tag0", 64'(wtag0), 64'(10));
      check("four_c1_tag1", 64'(wtag1), 64'(11));
      do_cycle();
      check("four_c2_tag0", 64'(wtag0), 64'(12));
      check("four_c2_tag1", 64'(wtag1), 64'(13));
      check("four_c2_pend", 64'(pending), 64'(1));
      do_cycle();
      check("four_end_pend", 64'(pending), 64'(0));

      // FU0 alone pushing every cycle never sees backpressure.
      for (int c = 0; c < 8; c++) begin
         set_idle();
         fu_valid[0] = 1'b1;
         fu_tag[0]   = core_pkg::preg_tag_t'(c);
         fu_data[0]  = $urandom;
         check("fu0_alone_ready", 64'(fu_ready[0]), 64'(1));
         do_cycle();
      end

      // All sources pushing continuously: FIFOs fill and ready toggles.
      for (int c = 0; c < 30; c++) begin
         set_random(0);
         fu_valid = 4'hF;
         do_cycle();
      end

      // Flush while busy, with pushes offered on the flush cycle.
      set_random(0);
      fu_valid = 4'hF;
      flush    = 1'b1;
      do_cycle();
      check("flush_ready",   64'(fu_ready), 64'hF);
      check("flush_pending", 64'(pending),  64'(0));
      check("flush_wen1",    64'(wen1),     64'(0));

      for (int c = 0; c < 200; c++) begin
         set_random(20);
         do_cycle();
      end

      // Asynchronous reset between edges while outputs are active.
      set_random(0);
      fu_valid = 4'hF;
      do_cycle();
      set_idle();
      #2 reset_n = 1'b0;
      #1;
      check("arst_wen0",    64'(wen0),     64'(0));
      check("arst_wen1",    64'(wen1),     64'(0));
      check("arst_wtag0",   64'(wtag0),    64'(0));
      check("arst_wdata1",  64'(wdata1),   64'(0));
      check("arst_pending", 64'(pending),  64'(0));
      check("arst_ready",   64'(fu_ready), 64'hF);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) do_cycle();

      for (int c = 0; c < 200; c++) begin
         set_random(20);
         do_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
